key_input_ctrl: RTL and testbench

Keyboard input controller. It sequences capture of keycode bytes from the keyboard receiver (strobe/oflag plus keycode byte) into a small first-word-fall-through queue, and hands them to the CPU-side reader through a read-acknowledge handshake. It replaces free-running byte latching with edge-qualified capture, overflow tracking and optional PS/2 break-code filtering. It sits between the keyboard receiver and the CPU I/O read port.

---
 rtl/key_pkg.sv | 12 +
 rtl/key_fifo.sv | 56 +++++
 rtl/key_input_ctrl.sv | 98 +++++++++
 tb/tb_key_input_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and state type for the keyboard input controller.
package key_pkg;

  localparam int KEY_W         = 8;
  localparam int KEY_DEPTH_DEF = 4;

  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;

  typedef enum logic {NORM, SKIP} key_state_t;

endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through keycode queue with separate occupancy count.
// Push and pop are qualified internally; a push into a full queue only lands with a same-cycle pop.
module key_fifo
  import key_pkg::*;
#(
  parameter int DEPTH = KEY_DEPTH_DEF,
  parameter int W     = KEY_W
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; visibility is governed entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_input_ctrl.sv
// Keyboard input controller: strobe edge capture, keycode queue, sticky overflow.
// Define KEYCTRL_BREAK_FILTER_EN to drop PS/2 break sequences (F0 xx) and E0 prefixes.
module key_input_ctrl
  import key_pkg::*;
#(
  parameter int DEPTH = KEY_DEPTH_DEF,
  parameter int W     = KEY_W
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   strobe,
  input  logic [W-1:0]           din,
  input  logic                   rd_en,
  input  logic                   clr_ovf,
  output logic [W-1:0]           dout,
  output logic                   valid,
  output logic                   full,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);

  logic          strobe_q;
  logic          capture;
  logic          filtered;
  logic          push_req;
  logic          pop_ok;
  logic          ovf_set;
  logic [W-1:0]  head;

  assign capture  = strobe && !strobe_q;
  assign pop_ok   = rd_en && valid;
  assign push_req = capture && !filtered;
  assign ovf_set  = push_req && full && !pop_ok;
  assign dout     = valid ? head : '0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) strobe_q <= 1'b0;
    else       strobe_q <= strobe;
  end

`ifdef KEYCTRL_BREAK_FILTER_EN
  key_state_t state;
  key_state_t state_next;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= NORM;
    else       state <= state_next;
  end

  // The byte following a break code is the released key; swallow it too.
  always_comb begin
    state_next = state;
    filtered   = 1'b0;
    if (capture) begin
      case (state)
        NORM: begin
          if (din == W'(KEY_BREAK)) begin
            state_next = SKIP;
            filtered   = 1'b1;
          end else if (din == W'(KEY_EXT)) begin
            filtered   = 1'b1;
          end
        end
        SKIP: begin
          state_next = NORM;
          filtered   = 1'b1;
        end
        default: state_next = NORM;
      endcase
    end
  end
`else
  assign filtered = 1'b0;
`endif

  // Set takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)        overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  key_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push_req),
    .pop   (rd_en),
    .din   (din),
    .head  (head),
    .valid (valid),
    .full  (full),
    .count (count)
  );

endmodule

// File: tb/tb_key_input_ctrl.sv
// Self-checking bench for key_input_ctrl: directed scenarios plus randomized traffic
// against a queue-based reference model (honours KEYCTRL_BREAK_FILTER_EN).
module tb_key_input_ctrl;

  localparam int DEPTH = 4;
  localparam int W     = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          nrst;
  logic          strobe;
  logic [W-1:0]  din;
  logic          rd_en;
  logic          clr_ovf;
  logic [W-1:0]  dout;
  logic          valid;
  logic          full;
  logic          overflow;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] m_q[$];
  bit           m_ovf;
  bit           m_sq;
  bit           m_skip;

  always #5 clk = ~clk;

  key_input_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .strobe   (strobe),
    .din      (din),
    .rd_en    (rd_en),
    .clr_ovf  (clr_ovf),
    .dout     (dout),
    .valid    (valid),
    .full     (full),
    .overflow (overflow),
    .count    (count)
  );

  function automatic void model_reset();
    m_q.delete();
    m_ovf  = 0;
    m_sq   = 0;
    m_skip = 0;
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  function automatic void model_step();
    bit cap, drop, pop, set;
    int sz;
    cap  = strobe && !m_sq;
    drop = 0;
`ifdef KEYCTRL_BREAK_FILTER_EN
    if (cap) begin
      if (m_skip) begin
        m_skip = 0;
        drop   = 1;
      end else if (din == 8'hF0) begin
        m_skip = 1;
        drop   = 1;
      end else if (din == 8'hE0) begin
        drop   = 1;
      end
    end
`endif
    sz  = m_q.size();
    pop = rd_en && (sz > 0);
    set = 0;
    if (pop) void'(m_q.pop_front());
    if (cap && !drop) begin
      if (sz < DEPTH || pop) m_q.push_back(din);
      else set = 1;
    end
    if (set) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    m_sq = strobe;
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [W-1:0] b);
    strobe = 1'b1;
    din    = b;
    step();
    strobe = 1'b0;
    step();
  endtask

  task automatic do_reset();
    nrst    = 1'b0;
    strobe  = 1'b0;
    din     = '0;
    rd_en   = 1'b0;
    clr_ovf = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    nrst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dout !== 8'h00 || valid !== 1'b0 || count !== '0 || overflow !== 1'b0 || full !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: dout=%h valid=%b count=%0d ovf=%b full=%b, required 00 0 0 0 0",
               dout, valid, count, overflow, full);
    end
    pulse(8'h1C);
    n_checks++;
    if (dout !== 8'h1C || valid !== 1'b1 || count !== CW'(1)) begin
      n_fail++;
      $display("[TB] FAIL first_capture: dout=%h valid=%b count=%0d, required 1c 1 1", dout, valid, count);
    end
  endtask

  task automatic test_long_strobe();
    do_reset();
    strobe = 1'b1;
    din    = 8'h32;
    for (int i = 0; i < 10; i++) step();
    strobe = 1'b0;
    step();
    n_checks++;
    if (count !== CW'(1) || dout !== 8'h32) begin
      n_fail++;
      $display("[TB] FAIL long_strobe: count=%0d dout=%h, required 1 32", count, dout);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] bytes [5];
    bytes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    do_reset();
    for (int i = 0; i < 5; i++) pulse(bytes[i]);
    n_checks++;
    if (full !== 1'b1 || overflow !== 1'b1 || count !== CW'(4)) begin
      n_fail++;
      $display("[TB] FAIL overflow_set: full=%b ovf=%b count=%0d, required 1 1 4", full, overflow, count);
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL overflow_clear: ovf=%b, required 0", overflow);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dout !== bytes[i]) begin
        n_fail++;
        $display("[TB] FAIL pop_order[%0d]: dout=%h, required %h", i, dout, bytes[i]);
      end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    n_checks++;
    if (dout !== 8'h00 || valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL drained: dout=%h valid=%b, required 00 0", dout, valid);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_checks++;
    if (count !== '0 || valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL empty_pop: count=%0d valid=%b, required 0 0", count, valid);
    end
  endtask

  task automatic test_push_pop_full();
    logic [W-1:0] exp [4];
    exp = '{8'h22, 8'h33, 8'h44, 8'h45};
    do_reset();
    pulse(8'h11); pulse(8'h22); pulse(8'h33); pulse(8'h44);
    strobe = 1'b1;
    din    = 8'h45;
    rd_en  = 1'b1;
    step();
    strobe = 1'b0;
    rd_en  = 1'b0;
    n_checks++;
    if (count !== CW'(4) || overflow !== 1'b0 || dout !== 8'h22 || full !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL push_pop_full: count=%0d ovf=%b dout=%h full=%b, required 4 0 22 1",
               count, overflow, dout, full);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dout !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL push_pop_order[%0d]: dout=%h, required %h", i, dout, exp[i]);
      end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
  endtask

  task automatic test_filter();
    logic [W-1:0] seq [5];
`ifdef KEYCTRL_BREAK_FILTER_EN
    logic [W-1:0] exp [2];
    bit           exp_ovf = 1'b0;
    exp = '{8'h1C, 8'h75};
`else
    logic [W-1:0] exp [4];
    bit           exp_ovf = 1'b1;
    exp = '{8'h1C, 8'hF0, 8'h1C, 8'hE0};
`endif
    seq = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75};
    do_reset();
    for (int i = 0; i < 5; i++) pulse(seq[i]);
    n_checks++;
    if (count !== CW'($size(exp)) || overflow !== exp_ovf) begin
      n_fail++;
      $display("[TB] FAIL filter_count: count=%0d ovf=%b, required %0d %b", count, overflow, $size(exp), exp_ovf);
    end
    for (int i = 0; i < $size(exp); i++) begin
      n_checks++;
      if (dout !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL filter_order[%0d]: dout=%h, required %h", i, dout, exp[i]);
      end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    pulse(8'h4B); pulse(8'hF0); pulse(8'h52); pulse(8'hF0);
    #2;
    nrst = 1'b0;
    #1;
    n_checks++;
    if (dout !== 8'h00 || valid !== 1'b0 || count !== '0 || overflow !== 1'b0 || full !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: dout=%h valid=%b count=%0d ovf=%b full=%b, required 00 0 0 0 0",
               dout, valid, count, overflow, full);
    end
    @(posedge clk);
    #1;
    model_reset();
    nrst = 1'b1;
    pulse(8'h29);
    n_checks++;
    if (dout !== 8'h29 || count !== CW'(1)) begin
      n_fail++;
      $display("[TB] FAIL post_reset_capture: dout=%h count=%0d, required 29 1", dout, count);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] pool [6];
    logic [W-1:0] exp_dout;
    pool = '{8'h1C, 8'hF0, 8'hE0, 8'h5A, 8'h75, 8'h29};
    do_reset();
    for (int i = 0; i < 400; i++) begin
      strobe  = ($urandom_range(0, 2) != 0);
      din     = ($urandom_range(0, 3) == 0) ? W'($urandom) : pool[$urandom_range(0, 5)];
      rd_en   = ($urandom_range(0, 2) == 0);
      clr_ovf = ($urandom_range(0, 9) == 0);
      step();
      exp_dout = (m_q.size() > 0) ? m_q[0] : 8'h00;
      n_checks++;
      if (dout !== exp_dout || valid !== (m_q.size() > 0) || count !== CW'(m_q.size()) ||
          full !== (m_q.size() == DEPTH) || overflow !== m_ovf) begin
        n_fail++;
        $display("[TB] FAIL random[%0d]: dout=%h valid=%b count=%0d full=%b ovf=%b, required %h %b %0d %b %b",
                 i, dout, valid, count, full, overflow, exp_dout, m_q.size() > 0, m_q.size(),
                 m_q.size() == DEPTH, m_ovf);
      end
    end
    strobe  = 1'b0;
    rd_en   = 1'b0;
    clr_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_long_strobe();
    test_overflow();
    test_push_pop_full();
    test_filter();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
